// File: rtl/multi_channel_data_synchronizer.sv
// Multi-channel receive-side CDC: per-channel enable synchronizer, level/toggle event decode,
// data capture with valid/ready hold, ack level and sticky overrun flag.
module multi_channel_data_synchronizer #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic                        overrun_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           ack,
  output logic [NUM_CH-1:0]           overrun
);

  logic [NUM_STAGES-1:0] chain [NUM_CH];
  logic [NUM_CH-1:0]     prev;
  logic [NUM_CH-1:0]     last_c;
  logic [NUM_CH-1:0]     event_c;
  logic [NUM_CH-1:0]     overrun_set_c;

  // Last synchronizer stage of each channel; doubles as the ack level.
  always_comb begin
    last_c = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      last_c[ch] = chain[ch][NUM_STAGES-1];
    end
  end

  assign ack = last_c;

  // Event decode from registered state only; overrun when an event hits unconsumed data.
  always_comb begin
    event_c       = '0;
    overrun_set_c = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (TOGGLE_MODE != 0) begin
        event_c[ch] = last_c[ch] ^ prev[ch];
      end else begin
        event_c[ch] = last_c[ch] & ~prev[ch];
      end
      overrun_set_c[ch] = event_c[ch] & sync_valid[ch] & ~sync_ready[ch];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        chain[ch] <= '0;
      end
      prev         <= '0;
      sync_bus     <= '0;
      enable_pulse <= '0;
      sync_valid   <= '0;
      overrun      <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        chain[ch] <= NUM_STAGES'({chain[ch], bus_enable[ch]});
        if (event_c[ch]) begin
          sync_bus[ch*BUS_WIDTH +: BUS_WIDTH] <= unsync_bus[ch*BUS_WIDTH +: BUS_WIDTH];
          enable_pulse[ch]                    <= 1'b1;
          sync_valid[ch]                      <= 1'b1;
        end else begin
          enable_pulse[ch] <= 1'b0;
          if (sync_valid[ch] && sync_ready[ch]) begin
            sync_valid[ch] <= 1'b0;
          end
        end
      end
      prev <= last_c;
      // A new overrun on the same edge as a clear keeps the flag set.
      overrun <= overrun_set_c | (overrun & ~{NUM_CH{overrun_clr}});
    end
  end

endmodule

// File: tb/tb_multi_channel_data_synchronizer.sv
// Bench for multi_channel_data_synchronizer: level and toggle instances, directed table,
// hand sequences and random stimulus against a sample-history reference model.
module tb_multi_channel_data_synchronizer;

  localparam int unsigned BW = 8;
  localparam int unsigned NS = 2;
  localparam int unsigned NC = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [NC*BW-1:0] ub_l, ub_t, sb_l, sb_t;
  logic [NC-1:0]    en_l, en_t, rd_l, rd_t;
  logic [NC-1:0]    ep_l, ep_t, sv_l, sv_t, ak_l, ak_t, ov_l, ov_t;
  logic             clr_l, clr_t;

  multi_channel_data_synchronizer #(
    .BUS_WIDTH(BW), .NUM_STAGES(NS), .NUM_CH(NC), .TOGGLE_MODE(0)
  ) dut_lvl (
    .CLK(CLK), .RST(RST), .unsync_bus(ub_l), .bus_enable(en_l), .sync_ready(rd_l),
    .overrun_clr(clr_l), .sync_bus(sb_l), .enable_pulse(ep_l), .sync_valid(sv_l),
    .ack(ak_l), .overrun(ov_l)
  );

  multi_channel_data_synchronizer #(
    .BUS_WIDTH(BW), .NUM_STAGES(NS), .NUM_CH(NC), .TOGGLE_MODE(1)
  ) dut_tgl (
    .CLK(CLK), .RST(RST), .unsync_bus(ub_t), .bus_enable(en_t), .sync_ready(rd_t),
    .overrun_clr(clr_t), .sync_bus(sb_t), .enable_pulse(ep_t), .sync_valid(sv_t),
    .ack(ak_t), .overrun(ov_t)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference model: enable samples since the last reset; ack is the sample NS-1 edges old,
  // an event compares the samples NS and NS+1 edges old.
  logic [NC-1:0]    hist_l[$];
  logic [NC-1:0]    hist_t[$];
  logic [NC*BW-1:0] m_bus   [2];
  logic [NC-1:0]    m_pulse [2];
  logic [NC-1:0]    m_valid [2];
  logic [NC-1:0]    m_ovr   [2];
  logic [NC-1:0]    m_ack   [2];

  function automatic logic samp(input int i, input int k, input int c);
    logic [NC-1:0] v;
    if (k < 1) return 1'b0;
    v = (i == 0) ? hist_l[k-1] : hist_t[k-1];
    return v[c];
  endfunction

  task automatic model_step(input int i, input logic [NC-1:0] en, input logic [NC*BW-1:0] d,
                            input logic [NC-1:0] rdy, input logic clr);
    int n;
    logic last, prv, ev, ovset;
    if (i == 0) hist_l.push_back(en); else hist_t.push_back(en);
    n = (i == 0) ? hist_l.size() : hist_t.size();
    for (int c = 0; c < int'(NC); c++) begin
      last  = samp(i, n - int'(NS), c);
      prv   = samp(i, n - int'(NS) - 1, c);
      ev    = (i == 1) ? (last ^ prv) : (last & ~prv);
      ovset = ev & m_valid[i][c] & ~rdy[c];
      if (ev) begin
        m_bus[i][c*BW +: BW] = d[c*BW +: BW];
        m_pulse[i][c] = 1'b1;
        m_valid[i][c] = 1'b1;
      end else begin
        m_pulse[i][c] = 1'b0;
        if (m_valid[i][c] && rdy[c]) m_valid[i][c] = 1'b0;
      end
      if (ovset) m_ovr[i][c] = 1'b1;
      else if (clr) m_ovr[i][c] = 1'b0;
      m_ack[i][c] = samp(i, n - int'(NS) + 1, c);
    end
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      hist_l.delete();
      hist_t.delete();
      for (int i = 0; i < 2; i++) begin
        m_bus[i] = '0; m_pulse[i] = '0; m_valid[i] = '0; m_ovr[i] = '0; m_ack[i] = '0;
      end
    end else begin
      model_step(0, en_l, ub_l, rd_l, clr_l);
      model_step(1, en_t, ub_t, rd_t, clr_t);
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("lvl.sync_bus",     32'(sb_l), 32'(m_bus[0]));
      chk("lvl.enable_pulse", 32'(ep_l), 32'(m_pulse[0]));
      chk("lvl.sync_valid",   32'(sv_l), 32'(m_valid[0]));
      chk("lvl.ack",          32'(ak_l), 32'(m_ack[0]));
      chk("lvl.overrun",      32'(ov_l), 32'(m_ovr[0]));
      chk("tgl.sync_bus",     32'(sb_t), 32'(m_bus[1]));
      chk("tgl.enable_pulse", 32'(ep_t), 32'(m_pulse[1]));
      chk("tgl.sync_valid",   32'(sv_t), 32'(m_valid[1]));
      chk("tgl.ack",          32'(ak_t), 32'(m_ack[1]));
      chk("tgl.overrun",      32'(ov_t), 32'(m_ovr[1]));
    end
  end

  // Directed level-mode vectors on channel 0: inputs applied, then outputs after the edge.
  typedef struct packed {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       ack;
    logic       pulse;
    logic       valid;
    logic       ovr;
    logic [7:0] bus;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back(vec_t'{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04});
    tbl.push_back(vec_t'{1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04});
    tbl.push_back(vec_t'{1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04});

    // Reset held with both enables high: everything stays 0.
    RST = 1'b1;
    en_l = 2'b11; en_t = 2'b11; rd_l = '0; rd_t = '0; clr_l = 1'b0; clr_t = 1'b0;
    ub_l = 16'hC33C; ub_t = 16'h6996;
    repeat (3) cyc();
    chk("rst.lvl_outs", {sb_l, ep_l, sv_l, ak_l, ov_l}, 32'h0);
    chk("rst.tgl_outs", {sb_t, ep_t, sv_t, ak_t, ov_t}, 32'h0);
    chk_on = 1'b1;

    // Release: enable already high counts as an edge, both channels pulse 3 edges later.
    RST = 1'b0;
    cyc();
    chk("rel.e1_pulse", 32'({ep_l, ep_t}), 32'h0);
    cyc();
    chk("rel.e2_ack", 32'({ak_l, ak_t}), 32'hF);
    chk("rel.e2_pulse", 32'({ep_l, ep_t}), 32'h0);
    cyc();
    chk("rel.e3_pulse", 32'({ep_l, ep_t}), 32'hF);
    chk("rel.indep_bus_lvl", 32'(sb_l), 32'hC33C);
    chk("rel.indep_bus_tgl", 32'(sb_t), 32'h6996);
    cyc();
    chk("rel.e4_pulse", 32'({ep_l, ep_t}), 32'h0);

    // Mid-operation reset on the edge the pulse would have been due.
    en_l = 2'b00; en_t = 2'b00; rd_l = 2'b11; rd_t = 2'b11;
    repeat (4) cyc();
    en_l = 2'b11; ub_l = 16'h5AA5;
    cyc();
    cyc();
    chk("midrst.ack_before", 32'(ak_l), 32'h3);
    RST = 1'b1;
    cyc();
    chk("midrst.lvl_outs", {sb_l, ep_l, sv_l, ak_l, ov_l}, 32'h0);
    en_l = 2'b00; rd_l = '0; rd_t = '0;
    cyc();
    chk("midrst.still_zero", {sb_l, ep_l, sv_l, ak_l, ov_l}, 32'h0);
    RST = 1'b0;
    cyc();

    // Table on level instance channel 0.
    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst; en_l[0] = tbl[i].en; ub_l[7:0] = tbl[i].d;
      rd_l[0] = tbl[i].rdy; clr_l = tbl[i].clr;
      cyc();
      chk($sformatf("tbl[%0d].ack", i),   32'(ak_l[0]), 32'(tbl[i].ack));
      chk($sformatf("tbl[%0d].pulse", i), 32'(ep_l[0]), 32'(tbl[i].pulse));
      chk($sformatf("tbl[%0d].valid", i), 32'(sv_l[0]), 32'(tbl[i].valid));
      chk($sformatf("tbl[%0d].ovr", i),   32'(ov_l[0]), 32'(tbl[i].ovr));
      chk($sformatf("tbl[%0d].bus", i),   32'(sb_l[7:0]), 32'(tbl[i].bus));
    end
    clr_l = 1'b0; rd_l = '0;

    // Toggle mode, channel 1: rising then falling enable each produce one capture.
    RST = 1'b1; en_t = 2'b00;
    cyc();
    RST = 1'b0;
    en_t[1] = 1'b1; ub_t[15:8] = 8'h11;
    cyc(); cyc();
    chk("tgl.rise_early", 32'(ep_t[1]), 32'h0);
    cyc();
    chk("tgl.rise_pulse", 32'(ep_t[1]), 32'h1);
    chk("tgl.rise_bus", 32'(sb_t[15:8]), 32'h11);
    cyc();
    chk("tgl.rise_once", 32'(ep_t[1]), 32'h0);
    en_t[1] = 1'b0; ub_t[15:8] = 8'h22;
    cyc(); cyc();
    chk("tgl.fall_early", 32'(ep_t[1]), 32'h0);
    cyc();
    chk("tgl.fall_pulse", 32'(ep_t[1]), 32'h1);
    chk("tgl.fall_bus", 32'(sb_t[15:8]), 32'h22);
    cyc();
    chk("tgl.fall_once", 32'(ep_t[1]), 32'h0);

    // Random traffic on both instances, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) en_l = en_l ^ NC'($urandom);
      if ($urandom_range(0, 1) == 0) en_t = en_t ^ NC'($urandom);
      ub_l = 16'($urandom); ub_t = 16'($urandom);
      rd_l = NC'($urandom); rd_t = NC'($urandom);
      clr_l = ($urandom_range(0, 15) == 0);
      clr_t = ($urandom_range(0, 15) == 0);
      cyc();
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_data_synchronizer.md
# multi_channel_data_synchronizer

Receive-side multi-bit CDC block that brings NUM_CH independent asynchronous data buses into the CLK domain, each qualified by its own enable. It is the next generation of the single-channel bus synchronizer with enable-pulse generation. It adds:
- per-channel level or toggle enable encoding;
- a valid/ready hold stage toward the consumer;
- an ack level for the return handshake;
- sticky overrun detection.

## Interface
Parameters:
- BUS_WIDTH, 8, data bits per channel (≥1)
- NUM_STAGES, 2, synchronizer flops on each enable (≥1)
- NUM_CH, 2, number of independent channels (≥1)
- TOGGLE_MODE, 0, 0 = level enable (a rising edge is an event); 1 = toggle enable (any edge is an event)

Ports (all sampled or driven on rising CLK; channel ch uses slice [ch*BUS_WIDTH +: BUS_WIDTH]):
- CLK  in  1  sole clock
- RST  in  1  reset, synchronous, active-high
- unsync_bus  in  NUM_CH*BUS_WIDTH  asynchronous data, flattened per channel
- bus_enable  in  NUM_CH  asynchronous per-channel enable
- sync_ready  in  NUM_CH  consumer accepts held data
- overrun_clr  in  1  clears all overrun flags
- sync_bus  out  NUM_CH*BUS_WIDTH  captured data, registered
- enable_pulse  out  NUM_CH  one-cycle pulse per capture, registered
- sync_valid  out  NUM_CH  held data not yet consumed
- ack  out  NUM_CH  synchronized enable level (last sync stage), for source return handshake
- overrun  out  NUM_CH  sticky; set when an event overwrote unconsumed data

## Operation
Each channel has the following logic, and channels are fully independent:
- Sync chain: NUM_STAGES flops on bus_enable[ch], followed by one edge-history flop prev.
- ack[ch] is the last chain stage, driven directly from that flop.
- Event, decoded from registered state:
  - TOGGLE_MODE=0: event = last & ~prev.
  - TOGGLE_MODE=1: event = last ^ prev.
- On the edge where event=1:
  - sync_bus[ch] <= unsync_bus[ch].
  - enable_pulse[ch] <= 1.
  - sync_valid[ch] <= 1.
- On any edge without an event, enable_pulse[ch] <= 0 and sync_bus[ch] holds.
- sync_valid clears on the edge where sync_valid & sync_ready & !event.
- Event on the same edge as valid & ready: the new data loads, valid stays 1, and overrun is not set.
- Event while valid & !ready: the new data overwrites the held data (latest wins) and overrun[ch] <= 1.
- overrun_clr=1 clears every overrun bit on that edge. If an overrun condition occurs on the same edge as the clear, set wins for that channel.
- Source contract: unsync_bus[ch] is held stable from before its enable edge until ack[ch] reflects that edge. The block does not check this.

## Timing
- Reset: while RST=1 at an edge, every flop goes to 0: the chain, prev, sync_bus, enable_pulse, sync_valid and overrun. Consequently every output is 0 in the cycle after that edge.
- Reset mid-operation discards held data and any in-flight event, with no partial capture.
- After reset release, a bus_enable already at 1 is treated as an edge from 0 in both modes. It produces one event NUM_STAGES+1 edges after release.
- Latency: bus_enable changes and is stable before edge E1.
  - ack changes after edge E_NUM_STAGES.
  - enable_pulse, sync_valid and new sync_bus are visible after edge E_NUM_STAGES+1.
  - With NUM_STAGES=2, capture occurs 3 edges after the first sampling edge.
- Enable_pulse width is exactly 1 cycle per event.
- Throughput: one event per 2 cycles per channel, since events need a 0 on prev between rising edges in level mode. Toggle mode allows one event per cycle.
- Falling edges in level mode generate no event, but ack still follows the synchronized level.

## Test plan
- Reset: RST=1 for 3 edges with bus_enable=2'b11 → all outputs 0. Release → both channels pulse after exactly 3 edges (NUM_STAGES=2).
- Level capture: ch0 unsync=8'hA5, bus_enable[0] 0→1 → ack[0]=1 after 2 edges. sync_bus[0]=8'hA5, enable_pulse[0]=1 for 1 cycle and sync_valid[0]=1 after 3 edges. Holding high gives no further pulses; the falling edge gives no pulse.
- Toggle mode (TOGGLE_MODE=1): ch1 enable toggles 0→1→0 with data 8'h11 then 8'h22, each held ≥4 cycles → two pulses, capturing 8'h11 then 8'h22.
- Valid/ready: sync_ready=0 after a capture → sync_valid stays 1. Ready=1 for one cycle → sync_valid 0 on the next edge and overrun stays 0.
- Overrun: capture 8'h01, keep ready=0, then a second event with 8'h02 → sync_bus=8'h02 and overrun[0]=1 (sticky). overrun_clr on the same edge as a third unconsumed event → overrun stays 1. A later clear with no event → 0.
- Channel independence and mid-operation reset: simultaneous events on ch0/ch1 with different data → independent captures. Reset asserted one edge before the pulse is due → no pulse and all outputs 0.
